instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction supplier for the 8-bit processor core. It is the producer side of the `instr` input that the control FSM consumes.
- Holds a loadable program memory and the program counter. Resolves CALL (0x15) and RETURN (0x16) internally, using a private return-address stack.
- Presents every other opcode to the core over a valid/ready handshake. Stops after HALT (0x13) has been accepted.

Parameters:
- MEM_DEPTH, 256, program memory words (8-bit each); address is pc[7:0].
- CALL_DEPTH, 8, return-address stack entries.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- load_en  in  1  program memory write strobe; honoured only in IDLE/HALTED/FAULT
- load_addr  in  8  program memory write address
- load_data  in  8  program memory write data
- start  in  1  begin execution at address 0; honoured only in IDLE/HALTED/FAULT
- instr  out  8  presented opcode
- instr_valid  out  1  instr is valid
- instr_ready  in  1  core accepts instr
- pc  out  8  address of the instruction being fetched or presented
- call_depth  out  4  number of occupied stack entries, 0..CALL_DEPTH
- busy  out  1  high in FETCH, DECODE, TGT_FETCH, TGT_DECODE and PRESENT
- halted  out  1  HALT accepted
- fault  out  1  stack underflow or overflow

Behaviour:
- Reset values: instr=0x00, instr_valid=0, pc=0, call_depth=0, busy=0, halted=0, fault=0, state=IDLE.
  - Memory contents are not cleared by reset.
- Memory: synchronous read with 1-cycle latency. The address is issued in FETCH or TGT_FETCH; data is used in the following state.
- A write on load_en takes effect at the clock edge. load_en outside IDLE/HALTED/FAULT is ignored.
- States:
  - IDLE: on start, pc<=0, call_depth<=0, halted<=0, fault<=0, then go to FETCH.
  - FETCH: read mem[pc]; go to DECODE.
  - DECODE, opcode q:
    - q=0x15 (CALL): pc<=pc+1; go to TGT_FETCH.
    - q=0x16 (RETURN): if call_depth=0, fault<=1 and go to FAULT. Otherwise pop: pc<=top entry, call_depth-1; go to FETCH.
    - Any other q: instr<=q, instr_valid<=1; go to PRESENT.
  - TGT_FETCH: read mem[pc] (the target byte); go to TGT_DECODE.
  - TGT_DECODE: if call_depth=CALL_DEPTH, fault<=1 and go to FAULT. Otherwise push pc+1 (the return address), call_depth+1, pc<=q; go to FETCH.
  - PRESENT: instr and instr_valid are held stable until instr_valid and instr_ready are both high at a clock edge. On that handshake:
    - If instr=0x13: instr_valid<=0, halted<=1; go to HALTED. pc stays at the HALT address.
    - Otherwise: instr_valid<=0, pc<=pc+1; go to FETCH.
  - HALTED / FAULT: idle. start restarts exactly as from IDLE. halted/fault stay high until start or reset.
- Latency:
  - start to first instr_valid = 3 cycles: start edge, FETCH, DECODE; valid is high from the 3rd edge.
  - With instr_ready held high, one instruction is delivered every 3 cycles.
  - A CALL adds 4 cycles before the target opcode is fetched. A RETURN adds 2.
- pc arithmetic is modulo 256: 0xFF+1 wraps to 0x00. A return address of 0xFF+1 wraps to 0x00.
- start or load_en while busy: ignored. instr_ready outside PRESENT: ignored.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous), including dropping instr_valid. The stack is emptied.

Test Plan:
- Straight-line program: mem[0..2]={0x00,0x01,0x13}, start, ready=1. Required: instr 0x00, 0x01, 0x13, each valid for one cycle, 3 cycles apart. After the HALT handshake: halted=1, busy=0, pc=2.
- Backpressure: program as above, ready=0 for 5 cycles after the first valid. Required: instr=0x00, instr_valid=1 and pc=0 held constant; handshake on the cycle ready rises.
- Call/return: mem[0]=0x15, mem[1]=0x10, mem[2]=0x13, mem[0x10]=0x07, mem[0x11]=0x16. Required: presented sequence 0x07 then 0x13, never 0x15 or 0x16. call_depth goes 0→1→0. pc=0x10 while 0x07 is presented and pc=2 while 0x13 is presented.
- Underflow: mem[0]=0x16, start. Required: fault=1, instr_valid never asserted, halted=0. A subsequent start after reloading mem[0]=0x13 presents 0x13 with fault cleared.
- Overflow: mem[0]=0x15, mem[1]=0x00 (self-recursion). Required: call_depth reaches 8; the 9th CALL sets fault=1 with call_depth=8. pc wrap: a HALT at 0x00 reached via 0xFF is presented after mem[0xFF]=0x05.
- Reset mid-PRESENT, with ready=0 and a load_en pulse attempted while busy. Required: the load is ignored (memory unchanged). On reset assertion, instr_valid=0 and pc=0 immediately. The next start presents the same first opcode as before.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Instruction supplier for the 8-bit core. Holds a loadable
//            program memory and the program counter, and resolves CALL and
//            RETURN internally through a private return-address stack.
//            Every other opcode goes to the core over a valid/ready
//            handshake. Execution stops once HALT has been accepted.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int MEM_DEPTH  = 256,
  parameter int CALL_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  input  logic       start,
  output logic [7:0] instr,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] pc,
  output logic [3:0] call_depth,
  output logic       busy,
  output logic       halted,
  output logic       fault
);

  // Opcodes the fetch unit interprets itself.
  localparam logic [7:0] c_op_halt   = 8'h13;
  localparam logic [7:0] c_op_call   = 8'h15;
  localparam logic [7:0] c_op_return = 8'h16;

  // Stack pointer width and the "stack full" depth value.
  localparam int         c_sp_w      = (CALL_DEPTH > 1) ? $clog2(CALL_DEPTH) : 1;
  localparam logic [3:0] c_depth_max = 4'(CALL_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_DECODE     = 3'd2,
    S_TGT_FETCH  = 3'd3,
    S_TGT_DECODE = 3'd4,
    S_PRESENT    = 3'd5,
    S_HALTED     = 3'd6,
    S_FAULT      = 3'd7
  } state_t;

  // Architectural state and its next-state values.
  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [3:0]  depth_q, depth_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  // Program memory, its registered read port and the return-address stack.
  logic [7:0]  mem_q [MEM_DEPTH];
  logic [7:0]  rdata_q;
  logic [7:0]  stack_q [CALL_DEPTH];

  // Control strobes derived from the current state.
  logic        w_quiet;       // not executing: loads and start are honoured
  logic        w_load;        // program memory write this cycle
  logic        w_rd_en;       // program memory read address issued this cycle
  logic        w_push;        // push a return address this cycle
  logic [7:0]  w_push_data;
  logic [c_sp_w-1:0] w_push_idx;
  logic [c_sp_w-1:0] w_pop_idx;
  logic [7:0]  w_pc_inc;

  assign w_quiet    = (state_q == S_IDLE) || (state_q == S_HALTED) || (state_q == S_FAULT);
  assign w_load     = load_en && w_quiet;
  assign w_rd_en    = (state_q == S_FETCH) || (state_q == S_TGT_FETCH);
  assign w_pc_inc   = pc_q + 8'd1;                       // wraps 0xFF -> 0x00
  assign w_push_idx = c_sp_w'(depth_q);                  // next free slot
  assign w_pop_idx  = c_sp_w'(depth_q - 4'd1);           // current top entry

  // Program memory write port and synchronous read port (1-cycle latency).
  always_ff @(posedge clk) begin
    if (w_load) begin
      mem_q[load_addr] <= load_data;
    end
    if (w_rd_en) begin
      rdata_q <= mem_q[pc_q];
    end
  end

  // Return-address stack storage; occupancy lives in depth_q, so reset only
  // needs to clear the depth to empty the stack.
  always_ff @(posedge clk) begin
    if (w_push) begin
      stack_q[w_push_idx] <= w_push_data;
    end
  end

  // State and architectural registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= 8'h00;
      instr_q  <= 8'h00;
      valid_q  <= 1'b0;
      depth_q  <= 4'd0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      depth_q  <= depth_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state logic: sequencing, CALL/RETURN resolution and the handshake.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    depth_d     = depth_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    w_push      = 1'b0;
    w_push_data = w_pc_inc;

    case (state_q)
      S_IDLE, S_HALTED, S_FAULT: begin
        // A restart from HALTED/FAULT is identical to a start from IDLE.
        if (start) begin
          pc_d     = 8'h00;
          depth_d  = 4'd0;
          halted_d = 1'b0;
          fault_d  = 1'b0;
          valid_d  = 1'b0;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        state_d = S_DECODE;
      end

      S_DECODE: begin
        if (rdata_q == c_op_call) begin
          // Target byte follows the CALL opcode.
          pc_d    = w_pc_inc;
          state_d = S_TGT_FETCH;
        end else if (rdata_q == c_op_return) begin
          if (depth_q == 4'd0) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d    = stack_q[w_pop_idx];
            depth_d = depth_q - 4'd1;
            state_d = S_FETCH;
          end
        end else begin
          instr_d = rdata_q;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
      end

      S_TGT_FETCH: begin
        state_d = S_TGT_DECODE;
      end

      S_TGT_DECODE: begin
        if (depth_q == c_depth_max) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          // Return address is the byte after the target byte (modulo 256).
          w_push      = 1'b1;
          w_push_data = w_pc_inc;
          depth_d     = depth_q + 4'd1;
          pc_d        = rdata_q;
          state_d     = S_FETCH;
        end
      end

      S_PRESENT: begin
        if (valid_q && instr_ready) begin
          valid_d = 1'b0;
          if (instr_q == c_op_halt) begin
            // pc stays on the HALT address.
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end else begin
            pc_d    = w_pc_inc;
            state_d = S_FETCH;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign call_depth  = depth_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign busy        = (state_q == S_FETCH)      || (state_q == S_DECODE)  ||
                       (state_q == S_TGT_FETCH)  || (state_q == S_TGT_DECODE) ||
                       (state_q == S_PRESENT);

endmodule
`default_nettype wire
